add_mult_result_collector: RTL and testbench

//  Result-side endpoint of the pipelined ADD_MULT datapath. Captures each tagged
//  64-bit result on its done pulse and buffers it in an in-order FIFO.

---
 rtl/add_mult_result_collector_pkg.sv | 16 +
 rtl/add_mult_result_collector_fifo.sv | 57 +++++
 rtl/add_mult_result_collector.sv | 67 ++++++
 tb/tb_add_mult_result_collector.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/add_mult_result_collector_pkg.sv
// Shared types and defaults for the ADD_MULT result collector.
package add_mult_result_collector_pkg;

    localparam int unsigned TAG_W         = 8;
    localparam int unsigned VALUE_W       = 64;
    localparam int unsigned DEPTH_DEFAULT = 16;
    localparam int unsigned SKID_DEFAULT  = 4;

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic [VALUE_W-1:0] value;
        tag_t               tag;
    } result_t;

endpackage

// File: rtl/add_mult_result_collector_fifo.sv
// First-word fall-through synchronous FIFO, generic in element type and depth.
module sync_fifo_fwft #(
    parameter type         T     = logic [7:0],
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  T                           wr_data,
    output T                           rd_data_c,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     next_count_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_comb begin
        next_count_c = count;
        if (push && !pop) begin
            next_count_c = count + CW'(1);
        end else if (pop && !push) begin
            next_count_c = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= next_count_c;
            full  <= (next_count_c == CW'(DEPTH));
            empty <= (next_count_c == CW'(0));
        end
    end

    // Storage is not reset; reads of stale slots are masked by empty upstream.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/add_mult_result_collector.sv
// Result-side endpoint: buffers tagged results in order, throttles the pipes, flags drops.
module add_mult_result_collector
    import add_mult_result_collector_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned SKID  = SKID_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [VALUE_W-1:0]       in_result,
    input  tag_t                     in_tag,
    output logic                     global_stall,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [VALUE_W-1:0]       out_result,
    output tag_t                     out_tag,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] next_count;
    result_t       wr_entry;
    result_t       head;

    assign pop      = out_valid && out_ready;
    assign push     = in_valid && (!full || pop);
    assign wr_entry = '{value: in_result, tag: in_tag};

    sync_fifo_fwft #(
        .T     (result_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .wr_data      (wr_entry),
        .rd_data_c    (head),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .next_count_c (next_count)
    );

    assign out_valid  = !empty;
    assign out_result = out_valid ? head.value : '0;
    assign out_tag    = out_valid ? head.tag   : '0;

    // Stall tracks the post-edge occupancy so SKID slots remain for in-flight results.
    always_ff @(posedge clk) begin
        if (reset) begin
            global_stall <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            global_stall <= (next_count >= CW'(DEPTH - SKID));
            if (in_valid && full && !pop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_add_mult_result_collector.sv
// Directed and randomized checks of the result collector against a queue-based model.
module tb_add_mult_result_collector;
    import add_mult_result_collector_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned SKID  = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic [63:0]          in_result;
    tag_t                 in_tag;
    logic                 global_stall;
    logic                 out_valid;
    logic                 out_ready;
    logic [63:0]          out_result;
    tag_t                 out_tag;
    logic [4:0]           count;
    logic                 overflow;

    int checks   = 0;
    int failures = 0;

    result_t q[$];
    logic    m_ovf;
    logic    m_stall;

    add_mult_result_collector #(.DEPTH(DEPTH), .SKID(SKID)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_result    (in_result),
        .in_tag       (in_tag),
        .global_stall (global_stall),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_tag      (out_tag),
        .count        (count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("out_result", out_result, (q.size() != 0) ? q[0].value : 64'h0);
        chk("out_tag", 64'(out_tag), (q.size() != 0) ? 64'(q[0].tag) : 64'h0);
        chk("count", 64'(count), 64'(q.size()));
        chk("global_stall", 64'(global_stall), 64'(m_stall));
        chk("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    // One clock: drive inputs, advance the model by the documented rules, compare.
    task automatic cycle(input logic iv, input logic [63:0] res, input tag_t tg, input logic rdy);
        bit do_pop;
        bit is_full;
        in_valid  = iv;
        in_result = res;
        in_tag    = tg;
        out_ready = rdy;
        do_pop  = (q.size() != 0) && rdy;
        is_full = (q.size() == DEPTH);
        @(posedge clk);
        #1;
        if (do_pop) void'(q.pop_front());
        if (iv && (!is_full || do_pop)) q.push_back('{value: res, tag: tg});
        else if (iv) m_ovf = 1'b1;
        m_stall = (q.size() >= DEPTH - SKID);
        check_model();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        m_ovf   = 1'b0;
        m_stall = 1'b0;
        check_model();
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_result = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        m_ovf     = 1'b0;
        m_stall   = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Idle after reset
        for (int i = 0; i < 10; i++) cycle(1'b0, rnd64(), tag_t'($urandom()), 1'b0);

        // Single result with the fixed value 1.0
        cycle(1'b1, 64'h3FF0_0000_0000_0000, tag_t'(5), 1'b0);
        chk("single_valid", 64'(out_valid), 64'h1);
        chk("single_result", out_result, 64'h3FF0_0000_0000_0000);
        chk("single_tag", 64'(out_tag), 64'h5);
        cycle(1'b0, 64'h0, tag_t'(0), 1'b1);
        chk("single_drained_valid", 64'(out_valid), 64'h0);
        chk("single_drained_count", 64'(count), 64'h0);

        // Stall threshold at 12 entries
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, rnd64(), tag_t'(i), 1'b0);
            if (i == 10) chk("stall_below", 64'(global_stall), 64'h0);
        end
        chk("stall_rise", 64'(global_stall), 64'h1);
        cycle(1'b0, 64'h0, tag_t'(0), 1'b1);
        chk("stall_fall", 64'(global_stall), 64'h0);
        do_reset();

        // Overflow: 17 pushes, tag 16 dropped
        for (int i = 0; i < 17; i++) cycle(1'b1, rnd64(), tag_t'(i), 1'b0);
        chk("ovf_count", 64'(count), 64'd16);
        chk("ovf_flag", 64'(overflow), 64'h1);
        for (int i = 0; i < 16; i++) begin
            chk("ovf_drain_tag", 64'(out_tag), 64'(i));
            cycle(1'b0, 64'h0, tag_t'(0), 1'b1);
        end
        chk("ovf_empty", 64'(out_valid), 64'h0);
        chk("ovf_sticky", 64'(overflow), 64'h1);
        do_reset();

        // Full with simultaneous push and pop across the pointer wrap
        for (int i = 0; i < 16; i++) cycle(1'b1, rnd64(), tag_t'(i), 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, rnd64(), tag_t'(100 + i), 1'b1);
            chk("full_pp_count", 64'(count), 64'd16);
            chk("full_pp_ovf", 64'(overflow), 64'h0);
        end
        for (int i = 0; i < 16; i++) cycle(1'b0, 64'h0, tag_t'(0), 1'b1);
        do_reset();

        // Reset mid-stream at 7 entries
        for (int i = 0; i < 7; i++) cycle(1'b1, rnd64(), tag_t'(50 + i), 1'b0);
        chk("mid_stall", 64'(global_stall), 64'h0);
        do_reset();
        chk("mid_count", 64'(count), 64'h0);
        chk("mid_valid", 64'(out_valid), 64'h0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 64'h0, tag_t'(0), 1'b1);

        // Random traffic, including NaN/denormal-like patterns
        for (int i = 0; i < 400; i++) begin
            logic [63:0] v;
            v = rnd64();
            if ((i % 37) == 0) v = 64'h7FF8_0000_0000_0001;
            if ((i % 41) == 0) v = 64'h0000_0000_0000_0001;
            cycle(1'(($urandom() % 4) != 0), v, tag_t'($urandom()), 1'(($urandom() % 3) == 0));
        end
        for (int i = 0; i < 20; i++) cycle(1'b0, 64'h0, tag_t'(0), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
